lpif_state_ctrl: RTL and testbench
==================================

LPIF_STATE_CTRL -- requirements
Module: lpif_state_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of PCLK cycles to wait for state_sts to match state_req.
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: the upper layer requests a state change.
REQ-005 SHALL have port cmd_state, input, 4 bits: the requested LPIF state encoding.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the controller accepts a command.
REQ-007 SHALL have port cmd_done, output, 1 bit: one-cycle pulse on successful completion.
REQ-008 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on timeout.
REQ-009 SHALL have port state_req, output, 4 bits: the state request driven to the PHY.
REQ-010 SHALL have port state_sts, input, 4 bits: the state status reported by the PHY.
REQ-011 SHALL have port stall_req, input, 1 bit: the PHY stall request.
REQ-012 SHALL have port stall_ack, output, 1 bit: the stall acknowledge to the PHY.
REQ-013 SHALL have port tx_idle, input, 1 bit: high when no TLP or DLLP is in flight on the transmit path.
REQ-014 SHALL have port link_up, output, 1 bit: the link is in the Active state.

Function
REQ-015 SHALL use these encodings: NOP=4'b0000, ACTIVE=4'b0001, L1=4'b0100, L2=4'b1000, LINKRESET=4'b1001, RETRAIN=4'b1011, DISABLE=4'b1100.
REQ-016 SHALL implement request FSM states IDLE, DRAIN, REQ, WAIT_STS and RESP.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1, and cmd_state is latched into an internal tgt register.
REQ-018 SHALL transition IDLE->DRAIN on acceptance when tgt is L1, L2 or DISABLE, and IDLE->REQ otherwise.
REQ-019 SHALL remain in DRAIN until tx_idle=1, then move to REQ on the next edge.
REQ-020 SHALL drive state_req=tgt for exactly one cycle in REQ, then move to WAIT_STS; state_req SHALL be NOP in all other states.
REQ-021 SHALL, in WAIT_STS, move to RESP with cmd_done=1 in the cycle after state_sts==tgt is sampled.
REQ-022 SHALL keep cmd_done and cmd_err each high for one cycle in RESP, then return to IDLE; the minimum command latency is 3 cycles from acceptance to cmd_done.
REQ-023 SHALL ignore an unencoded cmd_state: it is accepted, then cmd_err pulses two cycles later, state_req is never driven, and the FSM returns to IDLE.
REQ-024 SHALL implement an independent stall handshake:
  - On stall_req=1, stall_ack rises the first cycle tx_idle=1 is sampled with stall_req still 1.
  - stall_ack holds while stall_req=1.
  - stall_ack falls the cycle after stall_req=0 is sampled.
REQ-025 SHALL hold the request FSM in its current state while stall_ack=1, except that WAIT_STS keeps monitoring.
REQ-026 SHALL register link_up as (state_sts==ACTIVE) with 1-cycle latency.
REQ-027 SHALL give priority to the stall handshake if stall_req rises in the same cycle a command is accepted; the command proceeds after the stall is released.

Reset
REQ-028 SHALL, on reset=0 (asynchronous assertion), set FSM=IDLE, tgt=NOP, state_req=NOP, and set cmd_ready, cmd_done, cmd_err, stall_ack, link_up and the timeout counter to 0.
REQ-029 SHALL deassert reset synchronously to PCLK; cmd_ready=1 on the first edge after release.
REQ-030 SHALL abandon a reset mid-command silently, with no cmd_done or cmd_err pulse.

Configuration
REQ-031 SHALL compile in a timeout when macro LPIF_STATE_TIMEOUT_EN is defined:
  - A 16-bit counter clears on entry to WAIT_STS and increments each cycle in WAIT_STS.
  - When the count reaches TIMEOUT_CYC-1 without a match, the FSM moves to RESP with cmd_err=1.
  - A match in the same cycle as the count reaching TIMEOUT_CYC-1 counts as success.
REQ-032 SHALL, without LPIF_STATE_TIMEOUT_EN, omit the counter, wait in WAIT_STS indefinitely, and tie cmd_err=0 except for the REQ-023 path.

Verification
REQ-033 SHALL cover this scenario: cmd_state=ACTIVE, state_sts=0001 two cycles after REQ -> state_req=0001 for 1 cycle, cmd_done pulse, link_up=1.
REQ-034 SHALL cover this scenario: cmd_state=L1 with tx_idle=0 for 5 cycles -> FSM stays in DRAIN for 5 cycles, then state_req=0100 for 1 cycle.
REQ-035 SHALL cover this scenario: stall_req=1 with tx_idle=0 for 3 cycles, then tx_idle=1 -> stall_ack rises on the 4th cycle and falls 1 cycle after stall_req=0.
REQ-036 SHALL cover this scenario: with LPIF_STATE_TIMEOUT_EN defined and TIMEOUT_CYC=16, cmd_state=RETRAIN and state_sts held at 0001 -> cmd_err pulse 16 cycles after WAIT_STS entry, and no cmd_done.
REQ-037 SHALL cover this scenario: reset asserted in WAIT_STS -> all outputs are 0 or NOP immediately, and cmd_ready=1 one edge after release.
REQ-038 SHALL cover this scenario: cmd_state=4'b0111 -> cmd_err pulse, with state_req remaining NOP throughout.

Source files
------------

// File: rtl/lpif_state_ctrl.sv
// LPIF state request controller: upper-layer command FSM, PHY stall handshake, link_up.
// Define LPIF_STATE_TIMEOUT_EN to bound the WAIT_STS phase to TIMEOUT_CYC cycles.
module lpif_state_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       PCLK,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_state,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic [3:0] state_req,
  input  logic [3:0] state_sts,
  input  logic       stall_req,
  output logic       stall_ack,
  input  logic       tx_idle,
  output logic       link_up
);

  typedef enum logic [3:0] {
    LP_NOP       = 4'b0000,
    LP_ACTIVE    = 4'b0001,
    LP_L1        = 4'b0100,
    LP_L2        = 4'b1000,
    LP_LINKRESET = 4'b1001,
    LP_RETRAIN   = 4'b1011,
    LP_DISABLE   = 4'b1100
  } lpif_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_WAIT_STS,
    S_RESP
  } fsm_e;

  fsm_e       state;
  logic [3:0] tgt;
  logic       pend;
  logic       stall_ack_nxt;
  logic       hold;
  logic       accept;
  logic       sts_match;
  logic       to_hit;
  logic [3:0] launch_tgt;

  function automatic logic is_encoded(input logic [3:0] s);
    case (s)
      LP_NOP, LP_ACTIVE, LP_L1, LP_L2,
      LP_LINKRESET, LP_RETRAIN, LP_DISABLE: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic needs_drain(input logic [3:0] s);
    return (s == LP_L1) || (s == LP_L2) || (s == LP_DISABLE);
  endfunction

`ifdef LPIF_STATE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt;
  assign to_hit = (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // hold uses the value stall_ack is about to take, so the FSM never moves
  // into a cycle where stall_ack is high; REQ therefore always lasts one cycle.
  assign stall_ack_nxt = stall_req & (stall_ack | tx_idle);
  assign hold          = stall_ack_nxt;
  assign accept        = cmd_valid & cmd_ready;
  assign sts_match     = (state_sts == tgt);
  assign launch_tgt    = accept ? cmd_state : tgt;

  always_ff @(posedge PCLK or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tgt       <= LP_NOP;
      pend      <= 1'b0;
      state_req <= LP_NOP;
      cmd_ready <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      stall_ack <= 1'b0;
      link_up   <= 1'b0;
`ifdef LPIF_STATE_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      stall_ack <= stall_ack_nxt;
      link_up   <= (state_sts == LP_ACTIVE);
      cmd_ready <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      state_req <= LP_NOP;

      case (state)
        S_IDLE: begin
          if (accept) tgt <= cmd_state;
          // A command accepted while a stall starts is parked until release.
          if (accept || pend) begin
            if (hold) begin
              pend <= 1'b1;
            end else begin
              pend <= 1'b0;
              if (needs_drain(launch_tgt)) begin
                state <= S_DRAIN;
              end else begin
                state <= S_REQ;
                if (is_encoded(launch_tgt)) state_req <= launch_tgt;
              end
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (tx_idle && !hold) begin
            state     <= S_REQ;
            state_req <= tgt;
          end
        end

        S_REQ: begin
          if (is_encoded(tgt)) begin
            state <= S_WAIT_STS;
          end else begin
            state   <= S_RESP;
            cmd_err <= 1'b1;
          end
`ifdef LPIF_STATE_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        S_WAIT_STS: begin
          if (sts_match) begin
            state    <= S_RESP;
            cmd_done <= 1'b1;
          end else if (to_hit) begin
            state   <= S_RESP;
            cmd_err <= 1'b1;
          end
`ifdef LPIF_STATE_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        S_RESP: begin
          if (!hold) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpif_state_ctrl.sv
// Directed self-checking bench for lpif_state_ctrl (TIMEOUT_CYC overridden to 16).
module tb_lpif_state_ctrl;

  logic       PCLK;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_state;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;
  logic [3:0] state_req;
  logic [3:0] state_sts;
  logic       stall_req;
  logic       stall_ack;
  logic       tx_idle;
  logic       link_up;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  lpif_state_ctrl #(.TIMEOUT_CYC(16)) dut (
    .PCLK      (PCLK),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_state (cmd_state),
    .cmd_ready (cmd_ready),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .state_req (state_req),
    .state_sts (state_sts),
    .stall_req (stall_req),
    .stall_ack (stall_ack),
    .tx_idle   (tx_idle),
    .link_up   (link_up)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_state = 4'b0000; state_sts = 4'b0000;
    stall_req = 1'b0; tx_idle = 1'b1;
    #2 reset = 1'b0;
    #2;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", cmd_ready); else pass_cnt++;
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL rst_req: got %b want 0000", state_req); else pass_cnt++;
    chk_cnt++; if ({cmd_done, cmd_err, stall_ack, link_up} !== 4'b0000)
      $display("FAIL rst_flags: got %b want 0000", {cmd_done, cmd_err, stall_ack, link_up}); else pass_cnt++;
    tick(); tick();
    reset = 1'b1;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rst_held_ready: got %b want 0", cmd_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_active();
    cmd_valid = 1'b1; cmd_state = 4'b0001; tick(); cmd_valid = 1'b0;
    chk_cnt++; if (state_req !== 4'b0001) $display("FAIL active_req: got %b want 0001", state_req); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL active_busy: got %b want 0", cmd_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL active_req_1cyc: got %b want 0000", state_req); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL active_early_done: got %b want 0", cmd_done); else pass_cnt++;
    state_sts = 4'b0001; tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL active_done: got %b want 1", cmd_done); else pass_cnt++;
    chk_cnt++; if (link_up !== 1'b1) $display("FAIL active_link_up: got %b want 1", link_up); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL active_done_pulse: got %b want 0", cmd_done); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL active_ready_back: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_min_latency();
    cmd_valid = 1'b1; cmd_state = 4'b0001; tick(); cmd_valid = 1'b0;
    tick();
    chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL minlat_early: got %b want 0", cmd_done); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL minlat_done: got %b want 1", cmd_done); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL minlat_ready: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_drain();
    tx_idle = 1'b0; cmd_valid = 1'b1; cmd_state = 4'b0100; tick(); cmd_valid = 1'b0;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL drain_busy: got %b want 0", cmd_ready); else pass_cnt++;
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL drain_req0: got %b want 0000", state_req); else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_cnt++; if (state_req !== 4'b0000) $display("FAIL drain_hold%0d: got %b want 0000", i, state_req); else pass_cnt++;
    end
    tx_idle = 1'b1; tick();
    chk_cnt++; if (state_req !== 4'b0100) $display("FAIL drain_req_l1: got %b want 0100", state_req); else pass_cnt++;
    tick();
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL drain_req_1cyc: got %b want 0000", state_req); else pass_cnt++;
    state_sts = 4'b0100; tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL drain_done: got %b want 1", cmd_done); else pass_cnt++;
    chk_cnt++; if (link_up !== 1'b0) $display("FAIL drain_link_down: got %b want 0", link_up); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL drain_ready: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_stall();
    stall_req = 1'b1; tx_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (stall_ack !== 1'b0) $display("FAIL stall_wait%0d: got %b want 0", i, stall_ack); else pass_cnt++;
    end
    tx_idle = 1'b1; tick();
    chk_cnt++; if (stall_ack !== 1'b1) $display("FAIL stall_rise: got %b want 1", stall_ack); else pass_cnt++;
    tx_idle = 1'b0; tick();
    chk_cnt++; if (stall_ack !== 1'b1) $display("FAIL stall_hold: got %b want 1", stall_ack); else pass_cnt++;
    stall_req = 1'b0; tick();
    chk_cnt++; if (stall_ack !== 1'b0) $display("FAIL stall_fall: got %b want 0", stall_ack); else pass_cnt++;
    tx_idle = 1'b1;
  endtask

  task automatic test_stall_hold();
    state_sts = 4'b0000;
    cmd_valid = 1'b1; cmd_state = 4'b0001; stall_req = 1'b1; tick(); cmd_valid = 1'b0;
    chk_cnt++; if (stall_ack !== 1'b1) $display("FAIL prio_ack: got %b want 1", stall_ack); else pass_cnt++;
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL prio_req_held: got %b want 0000", state_req); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL prio_ready: got %b want 0", cmd_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL prio_req_held2: got %b want 0000", state_req); else pass_cnt++;
    stall_req = 1'b0; tick();
    chk_cnt++; if (stall_ack !== 1'b0) $display("FAIL prio_ack_fall: got %b want 0", stall_ack); else pass_cnt++;
    chk_cnt++; if (state_req !== 4'b0001) $display("FAIL prio_req_go: got %b want 0001", state_req); else pass_cnt++;
    tick();
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL prio_req_1cyc: got %b want 0000", state_req); else pass_cnt++;
    stall_req = 1'b1; state_sts = 4'b0001; tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL wait_monitor_done: got %b want 1", cmd_done); else pass_cnt++;
    chk_cnt++; if (stall_ack !== 1'b1) $display("FAIL wait_monitor_ack: got %b want 1", stall_ack); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL resp_held_pulse: got %b want 0", cmd_done); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL resp_held_ready: got %b want 0", cmd_ready); else pass_cnt++;
    stall_req = 1'b0; tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL resp_release_ready: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_unencoded();
    cmd_valid = 1'b1; cmd_state = 4'b0111; tick(); cmd_valid = 1'b0;
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL unenc_req0: got %b want 0000", state_req); else pass_cnt++;
    chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL unenc_early_err: got %b want 0", cmd_err); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_err !== 1'b1) $display("FAIL unenc_err: got %b want 1", cmd_err); else pass_cnt++;
    chk_cnt++; if ({cmd_done, state_req} !== 5'b00000) $display("FAIL unenc_req1: got %b want 00000", {cmd_done, state_req}); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL unenc_err_pulse: got %b want 0", cmd_err); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL unenc_ready: got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic quiet;
    state_sts = 4'b0001;
    cmd_valid = 1'b1; cmd_state = 4'b1011; tick(); cmd_valid = 1'b0;
    chk_cnt++; if (state_req !== 4'b1011) $display("FAIL retrain_req: got %b want 1011", state_req); else pass_cnt++;
    tick();
`ifdef LPIF_STATE_TIMEOUT_EN
    quiet = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (cmd_err !== 1'b0 || cmd_done !== 1'b0) quiet = 1'b0;
    end
    chk_cnt++; if (quiet !== 1'b1) $display("FAIL to_quiet: got %b want 1", quiet); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_err !== 1'b1) $display("FAIL to_err: got %b want 1", cmd_err); else pass_cnt++;
    chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL to_no_done: got %b want 0", cmd_done); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL to_ready: got %b want 1", cmd_ready); else pass_cnt++;
    cmd_valid = 1'b1; cmd_state = 4'b1011; tick(); cmd_valid = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) tick();
    state_sts = 4'b1011; tick();
    chk_cnt++; if ({cmd_done, cmd_err} !== 2'b10) $display("FAIL to_edge_match: got %b want 10", {cmd_done, cmd_err}); else pass_cnt++;
    tick();
`else
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cmd_err !== 1'b0 || cmd_done !== 1'b0) quiet = 1'b0;
    end
    chk_cnt++; if (quiet !== 1'b1) $display("FAIL nto_quiet: got %b want 1", quiet); else pass_cnt++;
    state_sts = 4'b1011; tick();
    chk_cnt++; if ({cmd_done, cmd_err} !== 2'b10) $display("FAIL nto_done: got %b want 10", {cmd_done, cmd_err}); else pass_cnt++;
    tick();
`endif
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL retrain_ready: got %b want 1", cmd_ready); else pass_cnt++;
    state_sts = 4'b0001;
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_state = 4'b0001; tick();
    chk_cnt++; if (state_req !== 4'b0001) $display("FAIL b2b_req_a: got %b want 0001", state_req); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL b2b_done_a: got %b want 1", cmd_done); else pass_cnt++;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", cmd_ready); else pass_cnt++;
    tick(); cmd_valid = 1'b0;
    chk_cnt++; if (state_req !== 4'b0001) $display("FAIL b2b_req_b: got %b want 0001", state_req); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (cmd_done !== 1'b1) $display("FAIL b2b_done_b: got %b want 1", cmd_done); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_state = 4'b1011; tick(); cmd_valid = 1'b0;
    tick();
    stall_req = 1'b1; tx_idle = 1'b1; tick();
    chk_cnt++; if ({stall_ack, link_up} !== 2'b11) $display("FAIL mid_pre: got %b want 11", {stall_ack, link_up}); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if ({cmd_ready, cmd_done, cmd_err, stall_ack, link_up} !== 5'b00000)
      $display("FAIL mid_flags: got %b want 00000", {cmd_ready, cmd_done, cmd_err, stall_ack, link_up}); else pass_cnt++;
    chk_cnt++; if (state_req !== 4'b0000) $display("FAIL mid_req: got %b want 0000", state_req); else pass_cnt++;
    stall_req = 1'b0; state_sts = 4'b0000;
    tick();
    chk_cnt++; if ({cmd_ready, cmd_done, cmd_err} !== 3'b000) $display("FAIL mid_held: got %b want 000", {cmd_ready, cmd_done, cmd_err}); else pass_cnt++;
    reset = 1'b1; tick();
    chk_cnt++; if ({cmd_ready, cmd_done, cmd_err} !== 3'b100) $display("FAIL mid_release: got %b want 100", {cmd_ready, cmd_done, cmd_err}); else pass_cnt++;
    tick();
    chk_cnt++; if ({cmd_done, cmd_err} !== 2'b00) $display("FAIL mid_silent: got %b want 00", {cmd_done, cmd_err}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_active();
    test_min_latency();
    test_drain();
    test_stall();
    test_stall_hold();
    test_unencoded();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
